ring_serializer: RTL and testbench
==================================

RING_SERIALIZER -- requirements
Module: ring_serializer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the word width and the number of ring phases (N >= 2).
REQ-002 The block SHALL have port clk  input  1  clock; all state changes occur on the posedge.
REQ-003 The block SHALL have port clr_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port ld  input  1  load request; a word is accepted when ld=1 and ready=1 at a posedge.
REQ-005 The block SHALL have port d_in  input  N  parallel word to serialize.
REQ-006 The block SHALL have port hold  input  1  stall request; while it is 1, the current bit is frozen.
REQ-007 The block SHALL have port ready  output  1  block can accept a word this cycle.
REQ-008 The block SHALL have port sout  output  1  serial data bit, MSB first.
REQ-009 The block SHALL have port sout_valid  output  1  sout carries a valid bit this cycle.
REQ-010 The block SHALL have port phase  output  N  one-hot ring position of the current bit.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse after the last bit of a word transfers.

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 In IDLE, outputs SHALL be: ready=1, sout_valid=0, phase=0, sout=0.
REQ-014 An accept (ld=1 and ready=1 at a posedge) SHALL do all of the following on that edge: register d_in, load phase with a 1 in bit N-1 only, and enter SHIFT.
REQ-015 In SHIFT, sout SHALL be the OR of (stored word AND phase), combinationally, so stored bit N-1 is output first.
REQ-016 In SHIFT, sout_valid SHALL equal NOT hold.
REQ-017 A transfer SHALL be a posedge in SHIFT with hold=0.
REQ-018 On each transfer, phase SHALL rotate right by one, moving the bit from position i to i-1.
REQ-019 A transfer with phase bit 0 set is the last transfer; on it, phase SHALL become 0 and the state SHALL return to IDLE, unless REQ-022 applies.
REQ-020 With hold=1 in SHIFT, phase, the stored word and the state SHALL be unchanged.
REQ-021 In SHIFT, ready SHALL be 1 only when phase bit 0 = 1 and hold = 0.
REQ-022 If ld=1 during the last-transfer cycle, the new word SHALL be accepted on that same edge, with no idle gap: phase is reloaded to bit N-1 and the state remains SHIFT.
REQ-023 ld while ready=0 SHALL be ignored, and no word SHALL be queued.
REQ-024 done SHALL be a registered output, set to 1 for exactly the one cycle following the last-transfer edge, including in the back-to-back case.
REQ-025 done SHALL be 0 at all other times.
REQ-026 First-bit latency: the first bit SHALL be valid in the cycle after the accept edge.
REQ-027 With hold=0 throughout, a word SHALL take exactly N cycles.
REQ-028 Whenever the state is SHIFT, phase SHALL be one-hot, with exactly one bit set.
REQ-029 Whenever the state is IDLE, phase SHALL be all-zero.
REQ-030 d_in SHALL be sampled only on the accept edge; changes to d_in mid-word SHALL NOT affect sout.
REQ-031 hold in IDLE SHALL have no effect, and an accept SHALL proceed regardless of hold.

Reset
REQ-032 When clr_n=0 at a posedge, the block SHALL set the state to IDLE, phase=0, the stored word to 0 and done=0, overriding ld and hold.
REQ-033 Following REQ-032, ready=1, sout_valid=0 and sout=0 SHALL hold from the next cycle.
REQ-034 A reset mid-word SHALL abort the word, and SHALL NOT pulse done.
REQ-035 The first accept after reset SHALL be possible on the first posedge with clr_n=1.

Verification
REQ-036 Reset: clr_n=0 for 2 cycles with ld=1 and d_in=8'hFF -> ready=1, sout_valid=0, phase=8'h00, done=0.
REQ-037 Single word (N=8): accept d_in=8'hA5 with hold=0 -> on cycles 1..8, sout = 1,0,1,0,0,1,0,1, sout_valid=1, and phase = 80,40,20,10,08,04,02,01 -> on cycle 9, done=1, ready=1, phase=00.
REQ-038 Back-to-back: accept 8'hF0, then hold ld=1 with d_in=8'h0F at the last bit -> 16 contiguous valid bits 11110000 00001111, with done pulsing after bit 8 and after bit 16.
REQ-039 Hold: word 8'hC3, with hold=1 for 3 cycles starting at phase=8'h10 -> phase stays 10, sout stays 0 with sout_valid=0 for 3 cycles, then the sequence resumes; done occurs 11 cycles after the accept.
REQ-040 Busy ld plus mid-word reset: accept 8'h81, pulse ld with d_in=8'h7E at phase=8'h40 -> ignored, sout unaffected; then clr_n=0 at phase=8'h08 -> IDLE with no done pulse, and the next accept works normally.

Source files
------------

// File: rtl/ring_serializer.sv
// -----------------------------------------------------------------------------
// ring_serializer
//
// Parallel-to-serial converter driven by a one-hot "ring" phase register.
// A word is captured on an accept edge and sent MSB first. The current bit is
// selected by AND-ing the stored word with the one-hot phase and OR-reducing
// the result. Each transfer rotates the phase one position towards bit 0. When
// the phase reaches bit 0, that transfer is the last one for the word. A new
// word may be accepted on that same edge, so consecutive words leave no gap.
//
// Handshake (valid/ready):
//   - Load side: a word is taken on a posedge where ld=1 and ready=1. When
//     ready=0, ld is ignored and nothing is queued.
//   - Serial side: a bit transfers on a posedge where sout_valid=1. There is
//     no downstream ready. hold=1 freezes the current bit and drops
//     sout_valid for that cycle.
//
// Parameters
//   N           word width, which is also the number of ring phases (N >= 2)
//
// Ports
//   clk         clock; all state changes happen on the posedge
//   clr_n       synchronous active-low reset
//   ld          load request
//   d_in[N-1:0] parallel word; sampled only on the accept edge
//   hold        stall request; freezes phase, stored word and state
//   ready       block can accept a word this cycle
//   sout        serial data bit, MSB first
//   sout_valid  sout carries a valid bit this cycle
//   phase       one-hot ring position of the current bit (all-zero when idle)
//   done        registered one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module ring_serializer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         ld,
   input  logic [N-1:0] d_in,
   input  logic         hold,
   output logic         ready,
   output logic         sout,
   output logic         sout_valid,
   output logic [N-1:0] phase,
   output logic         done
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Phase value for the first (MSB) bit of a word.
   localparam logic [N-1:0] PHASE_FIRST = {1'b1, {(N-1){1'b0}}};

   state_t       state;
   logic [N-1:0] word;

   logic in_shift;
   logic transfer;
   logic last_xfer;
   logic accept;

   assign in_shift  = (state == SHIFT);
   assign transfer  = in_shift & ~hold;
   assign last_xfer = transfer & phase[0];

   // While idle the block is always ready. While shifting it is ready only
   // on the last-transfer cycle. This lets the next word follow directly.
   assign ready  = ~in_shift | last_xfer;
   assign accept = ld & ready;

   assign sout_valid = transfer;
   // The explicit in_shift gate keeps sout at 0 in IDLE. It does not rely on
   // phase already being zero there.
   assign sout = in_shift & (|(word & phase));

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state <= IDLE;
         phase <= '0;
         word  <= '0;
         done  <= 1'b0;
      end else begin
         // done tracks the last-transfer edge, including the back-to-back
         // case, and holds for exactly the following cycle.
         done <= last_xfer;
         case (state)
            IDLE: begin
               // hold has no effect in IDLE.
               if (accept) begin
                  word  <= d_in;
                  phase <= PHASE_FIRST;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (transfer) begin
                  if (phase[0]) begin
                     if (accept) begin
                        // Back-to-back reload: stay in SHIFT, no idle gap.
                        word  <= d_in;
                        phase <= PHASE_FIRST;
                     end else begin
                        phase <= '0;
                        state <= IDLE;
                     end
                  end else begin
                     phase <= {1'b0, phase[N-1:1]};
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ring_serializer.sv
// -----------------------------------------------------------------------------
// tb_ring_serializer
//
// Directed bench for ring_serializer with N=8. Every expected serial bit is
// pushed to exp_q when its word is accepted. A negedge monitor pops and
// compares one entry for each cycle in which sout_valid=1. Phase, ready,
// done and sout_valid are checked inline by the directed sequence.
//
// Timing: inputs change 1 time unit after a posedge. Inline checks run 1
// unit later. The monitor samples on the negedge.
// -----------------------------------------------------------------------------
module tb_ring_serializer;

   localparam int N = 8;
   localparam int W = 1;

   logic         clk;
   logic         clr_n;
   logic         ld;
   logic [N-1:0] d_in;
   logic         hold;
   logic         ready;
   logic         sout;
   logic         sout_valid;
   logic [N-1:0] phase;
   logic         done;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_fail;

   ring_serializer #(.N(N)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .ld         (ld),
      .d_in       (d_in),
      .hold       (hold),
      .ready      (ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .phase      (phase),
      .done       (done)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push_word(input logic [N-1:0] w);
      for (int i = N - 1; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   task automatic expect_state(input string tag, input logic [N-1:0] exp_phase,
                               input logic exp_valid, input logic exp_done);
      check({tag, "_phase"}, 32'(phase), 32'(exp_phase));
      check({tag, "_valid"}, 32'(sout_valid), 32'(exp_valid));
      check({tag, "_done"}, 32'(done), 32'(exp_done));
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (sout_valid === 1'b1) begin
         if (exp_q.size() == 0) check("sout_unexpected", 32'(sout), 32'hX);
         else check("sout_bit", 32'(sout), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- directed sequence ----------------
   initial begin : stim
      logic [N-1:0] w;
      n_checks = 0;
      n_fail   = 0;

      // ---- 1: reset, with ld=1 and d_in=FF overridden ----
      clr_n = 1'b0;
      ld    = 1'b1;
      d_in  = 8'hFF;
      hold  = 1'b0;
      cyc();
      cyc();
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_sout", 32'(sout), 32'd0);
      expect_state("rst", 8'h00, 1'b0, 1'b0);
      ld    = 1'b0;
      clr_n = 1'b1;
      cyc();
      check("rst_idle_ready", 32'(ready), 32'd1);
      expect_state("rst_idle", 8'h00, 1'b0, 1'b0);

      // ---- 2: single word A5 ----
      ld   = 1'b1;
      d_in = 8'hA5;
      settle();
      check("a5_ready_idle", 32'(ready), 32'd1);
      push_word(8'hA5);
      cyc();
      ld = 1'b0;
      for (int i = 0; i < N; i++) begin
         d_in = 8'($urandom_range(0, 255));
         settle();
         expect_state("a5_bit", 8'h80 >> i, 1'b1, 1'b0);
         cyc();
      end
      check("a5_end_ready", 32'(ready), 32'd1);
      expect_state("a5_end", 8'h00, 1'b0, 1'b1);
      cyc();
      check("a5_done_clear", 32'(done), 32'd0);
      check("a5_q_empty", 32'(exp_q.size()), 32'd0);

      // ---- 3: back-to-back F0 then 0F ----
      ld   = 1'b1;
      d_in = 8'hF0;
      push_word(8'hF0);
      cyc();
      ld = 1'b0;
      for (int i = 0; i < N; i++) begin
         d_in = 8'($urandom_range(0, 255));
         if (i == N - 1) begin
            ld   = 1'b1;
            d_in = 8'h0F;
         end
         settle();
         expect_state("b2b_w1", 8'h80 >> i, 1'b1, 1'b0);
         check("b2b_w1_ready", 32'(ready), (i == N - 1) ? 32'd1 : 32'd0);
         if (i == N - 1) push_word(8'h0F);
         cyc();
         ld = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         d_in = 8'($urandom_range(0, 255));
         settle();
         expect_state("b2b_w2", 8'h80 >> i, 1'b1, (i == 0) ? 1'b1 : 1'b0);
         cyc();
      end
      expect_state("b2b_end", 8'h00, 1'b0, 1'b1);
      cyc();
      check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

      // ---- 4: hold on word C3 at phase 10 for 3 cycles ----
      ld   = 1'b1;
      d_in = 8'hC3;
      push_word(8'hC3);
      cyc();
      ld = 1'b0;
      begin
         logic [N-1:0] ph;
         ph = 8'h80;
         for (int t = 1; t <= 11; t++) begin
            hold = (t >= 4 && t <= 6) ? 1'b1 : 1'b0;
            settle();
            check("hold_phase", 32'(phase), 32'(ph));
            check("hold_valid", 32'(sout_valid), hold ? 32'd0 : 32'd1);
            check("hold_done", 32'(done), 32'd0);
            if (hold) begin
               check("hold_sout", 32'(sout), 32'd0);
               check("hold_ready", 32'(ready), 32'd0);
            end
            if (!hold) ph = ph >> 1;
            cyc();
         end
      end
      hold = 1'b0;
      settle();
      expect_state("hold_end", 8'h00, 1'b0, 1'b1);
      cyc();
      check("hold_q_empty", 32'(exp_q.size()), 32'd0);

      // ---- 5: busy ld ignored, then mid-word reset ----
      ld   = 1'b1;
      d_in = 8'h81;
      push_word(8'h81);
      cyc();
      ld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            ld   = 1'b1;
            d_in = 8'h7E;
         end
         if (i == 4) clr_n = 1'b0;
         settle();
         expect_state("busy", 8'h80 >> i, 1'b1, 1'b0);
         if (i == 1) check("busy_ready", 32'(ready), 32'd0);
         cyc();
         ld = 1'b0;
      end
      // The reset edge aborts the word, so its remaining bits are dropped.
      exp_q.delete();
      clr_n = 1'b1;
      // First accept right after reset, with hold=1 in IDLE.
      w    = 8'($urandom_range(0, 255));
      ld   = 1'b1;
      d_in = w;
      hold = 1'b1;
      settle();
      check("abort_ready", 32'(ready), 32'd1);
      expect_state("abort", 8'h00, 1'b0, 1'b0);
      push_word(w);
      cyc();
      ld   = 1'b0;
      hold = 1'b0;
      for (int i = 0; i < N; i++) begin
         settle();
         expect_state("post_rst", 8'h80 >> i, 1'b1, 1'b0);
         cyc();
      end
      expect_state("post_rst_end", 8'h00, 1'b0, 1'b1);
      cyc();
      check("post_rst_done_clear", 32'(done), 32'd0);
      check("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
